// File: rtl/aheap_lbus_ctrl.sv
// Shares the host local bus among the AHeap table stages, running one cs_n/ack_n transaction at a time.
// Optional transaction watchdog is enabled by defining AHEAP_LBUS_TIMEOUT_EN.
module aheap_lbus_ctrl #(
  parameter int STAGE_NUM = 6,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 192,
  parameter int TIMEOUT   = 255
) (
  input  logic                          Clk,
  input  logic                          Reset_N,
  input  logic                          local_cs_n,
  input  logic                          local_rw,
  input  logic [ADDR_W+2:0]             local_addr,
  input  logic [DATA_W-1:0]             local_wdata,
  output logic [DATA_W-1:0]             local_rdata,
  output logic                          local_ack_n,
  output logic                          local_err,
  output logic [STAGE_NUM-1:0]          tab_cs_n,
  output logic                          tab_rw,
  output logic [ADDR_W-1:0]             tab_addr,
  output logic [DATA_W-1:0]             tab_wdata,
  input  logic [STAGE_NUM*DATA_W-1:0]   tab_rdata,
  input  logic [STAGE_NUM-1:0]          tab_ack_n
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0]           STAGE_LIM = 4'(STAGE_NUM);
  localparam logic [STAGE_NUM-1:0] CS_ONE    = STAGE_NUM'(1);

  state_t              state_reg, state_next;
  logic [2:0]          sel_reg, sel_next;
  logic                err_reg, err_next;
  logic                req_rw_reg, req_rw_next;
  logic [ADDR_W-1:0]   req_addr_reg, req_addr_next;
  logic [DATA_W-1:0]   req_wdata_reg, req_wdata_next;
  logic [STAGE_NUM-1:0] tab_cs_n_reg, tab_cs_n_next;
  logic                tab_rw_reg, tab_rw_next;
  logic [ADDR_W-1:0]   tab_addr_reg, tab_addr_next;
  logic [DATA_W-1:0]   tab_wdata_reg, tab_wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                ack_n_reg, ack_n_next;
  logic                lerr_reg, lerr_next;

  logic [2:0]          sel_in;
  logic                stage_ok;

  // Pad the per-stage ack/rdata to the full 3-bit index range; absent stages never ack.
  logic [7:0]          ack_pad;
  logic [DATA_W-1:0]   rdata_arr [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_pad
    if (gi < STAGE_NUM) begin : g_live
      assign ack_pad[gi]   = tab_ack_n[gi];
      assign rdata_arr[gi] = tab_rdata[gi*DATA_W +: DATA_W];
    end else begin : g_none
      assign ack_pad[gi]   = 1'b1;
      assign rdata_arr[gi] = '0;
    end
  end

  assign sel_in   = local_addr[ADDR_W+2:ADDR_W];
  assign stage_ok = ({1'b0, sel_in} < STAGE_LIM);

`ifdef AHEAP_LBUS_TIMEOUT_EN
  localparam int                WDOG_W   = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT);
  logic [WDOG_W-1:0] wdog_reg, wdog_next;

  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) wdog_reg <= '0;
    else         wdog_reg <= wdog_next;
  end
`endif

  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      err_reg       <= 1'b0;
      req_rw_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      tab_cs_n_reg  <= '1;
      tab_rw_reg    <= 1'b0;
      tab_addr_reg  <= '0;
      tab_wdata_reg <= '0;
      rdata_reg     <= '0;
      ack_n_reg     <= 1'b1;
      lerr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      err_reg       <= err_next;
      req_rw_reg    <= req_rw_next;
      req_addr_reg  <= req_addr_next;
      req_wdata_reg <= req_wdata_next;
      tab_cs_n_reg  <= tab_cs_n_next;
      tab_rw_reg    <= tab_rw_next;
      tab_addr_reg  <= tab_addr_next;
      tab_wdata_reg <= tab_wdata_next;
      rdata_reg     <= rdata_next;
      ack_n_reg     <= ack_n_next;
      lerr_reg      <= lerr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    err_next       = err_reg;
    req_rw_next    = req_rw_reg;
    req_addr_next  = req_addr_reg;
    req_wdata_next = req_wdata_reg;
    tab_cs_n_next  = tab_cs_n_reg;
    tab_rw_next    = tab_rw_reg;
    tab_addr_next  = tab_addr_reg;
    tab_wdata_next = tab_wdata_reg;
    rdata_next     = rdata_reg;
    ack_n_next     = ack_n_reg;
    lerr_next      = lerr_reg;
`ifdef AHEAP_LBUS_TIMEOUT_EN
    wdog_next      = wdog_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!local_cs_n && ack_n_reg) begin
          req_rw_next    = local_rw;
          req_addr_next  = local_addr[ADDR_W-1:0];
          req_wdata_next = local_wdata;
          sel_next       = sel_in;
          if (!stage_ok) begin
            err_next   = 1'b1;
            rdata_next = '0;
            state_next = ACK;
          end else begin
            err_next   = 1'b0;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Strobe and bus fields launch on the same edge so stages see them together.
        tab_cs_n_next  = ~(CS_ONE << sel_reg);
        tab_rw_next    = req_rw_reg;
        tab_addr_next  = req_addr_reg;
        tab_wdata_next = req_wdata_reg;
`ifdef AHEAP_LBUS_TIMEOUT_EN
        wdog_next      = '0;
`endif
        state_next     = WAIT;
      end
      WAIT: begin
        if (!ack_pad[sel_reg]) begin
          tab_cs_n_next = '1;
          rdata_next    = req_rw_reg ? rdata_arr[sel_reg] : '0;
          err_next      = 1'b0;
          ack_n_next    = 1'b0;
          lerr_next     = 1'b0;
          state_next    = ACK;
        end
`ifdef AHEAP_LBUS_TIMEOUT_EN
        else if (wdog_reg == WDOG_MAX) begin
          tab_cs_n_next = '1;
          rdata_next    = '1;
          err_next      = 1'b1;
          ack_n_next    = 1'b0;
          lerr_next     = 1'b1;
          state_next    = ACK;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
`endif
      end
      ACK: begin
        // Leave only once the host and the stage have both released, so a lingering stage ack cannot leak into the next request.
        if (local_cs_n && ack_pad[sel_reg]) begin
          ack_n_next = 1'b1;
          lerr_next  = 1'b0;
          state_next = IDLE;
        end else begin
          ack_n_next = 1'b0;
          lerr_next  = err_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign local_rdata = rdata_reg;
  assign local_ack_n = ack_n_reg;
  assign local_err   = lerr_reg;
  assign tab_cs_n    = tab_cs_n_reg;
  assign tab_rw      = tab_rw_reg;
  assign tab_addr    = tab_addr_reg;
  assign tab_wdata   = tab_wdata_reg;

endmodule

// File: tb/tb_aheap_lbus_ctrl.sv
// Directed bench for aheap_lbus_ctrl: host transactions against a behavioural model of six table stages.
// Covers both builds of AHEAP_LBUS_TIMEOUT_EN.
module tb_aheap_lbus_ctrl;
  localparam int SN = 6;
  localparam int AW = 14;
  localparam int DW = 192;
  localparam int TO = 16;

  logic              Clk = 1'b0;
  logic              Reset_N;
  logic              local_cs_n;
  logic              local_rw;
  logic [AW+2:0]     local_addr;
  logic [DW-1:0]     local_wdata;
  logic [DW-1:0]     local_rdata;
  logic              local_ack_n;
  logic              local_err;
  logic [SN-1:0]     tab_cs_n;
  logic              tab_rw;
  logic [AW-1:0]     tab_addr;
  logic [DW-1:0]     tab_wdata;
  logic [SN*DW-1:0]  tab_rdata;
  logic [SN-1:0]     tab_ack_n;

  int errors = 0;
  int checks = 0;

  aheap_lbus_ctrl #(.STAGE_NUM(SN), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .local_cs_n(local_cs_n), .local_rw(local_rw), .local_addr(local_addr),
    .local_wdata(local_wdata), .local_rdata(local_rdata), .local_ack_n(local_ack_n),
    .local_err(local_err), .tab_cs_n(tab_cs_n), .tab_rw(tab_rw), .tab_addr(tab_addr),
    .tab_wdata(tab_wdata), .tab_rdata(tab_rdata), .tab_ack_n(tab_ack_n)
  );

  always #5 Clk = ~Clk;

  // Stage model: ack ack_dly cycles after seeing its strobe (-1 = never),
  // keep ack low ack_hold cycles after the strobe is released.
  int            ack_dly  [SN];
  int            ack_hold [SN];
  int            cnt_q    [SN];
  int            hold_q   [SN];
  logic [SN-1:0] ack_r;
  logic [DW-1:0] stage_data [SN];

  assign tab_ack_n = ack_r;
  for (genvar gi = 0; gi < SN; gi++) begin : g_stage
    assign tab_rdata[gi*DW +: DW] = stage_data[gi];
  end

  always @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) begin
      ack_r <= '1;
      for (int i = 0; i < SN; i++) begin
        cnt_q[i]  <= 0;
        hold_q[i] <= 0;
      end
    end else begin
      for (int i = 0; i < SN; i++) begin
        if (!tab_cs_n[i]) begin
          if (ack_dly[i] >= 0 && cnt_q[i] >= ack_dly[i]) ack_r[i] <= 1'b0;
          cnt_q[i]  <= cnt_q[i] + 1;
          hold_q[i] <= ack_hold[i];
        end else begin
          cnt_q[i] <= 0;
          if (!ack_r[i]) begin
            if (hold_q[i] == 0) ack_r[i] <= 1'b1;
            else                hold_q[i] <= hold_q[i] - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int            lat;
  int            rel;
  logic [DW-1:0] rd;
  logic          er;
  logic [SN-1:0] cs_and;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wd;
  logic          t_rw;

  // Called #1 after a posedge. lat counts edges from the cs_n sampling edge (=1) until ack seen; -1 if budget ran out.
  task automatic host_txn(input logic rw, input logic [2:0] stg, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int budget);
    bit got = 0;
    local_rw    = rw;
    local_addr  = {stg, addr};
    local_wdata = wd;
    local_cs_n  = 1'b0;
    lat    = 0;
    cs_and = '1;
    t_addr = '0;
    t_wd   = '0;
    t_rw   = 1'b0;
    while (local_ack_n !== 1'b0 && lat < budget) begin
      @(posedge Clk); #1;
      lat++;
      cs_and &= tab_cs_n;
      if (!got && tab_cs_n != '1) begin
        got    = 1;
        t_addr = tab_addr;
        t_wd   = tab_wdata;
        t_rw   = tab_rw;
      end
    end
    if (local_ack_n !== 1'b0) lat = -1;
    rd = local_rdata;
    er = local_err;
    $display("txn rw=%0d stage=%0d addr=%h lat=%0d err=%0d rdata=%h", rw, stg, addr, lat, er, rd);
  endtask

  task automatic host_release(input int budget);
    local_cs_n = 1'b1;
    rel = 0;
    while (local_ack_n !== 1'b1 && rel < budget) begin
      @(posedge Clk); #1;
      rel++;
    end
    if (local_ack_n !== 1'b1) rel = -1;
    $display("release cycles=%0d", rel);
  endtask

  initial begin
    for (int i = 0; i < SN; i++) begin
      ack_dly[i]    = 0;
      ack_hold[i]   = 0;
      stage_data[i] = {DW{1'b0}} | (DW'(i + 1) << 96) | DW'(8'hC0 + i);
    end
    ack_dly[0]    = -1;
    ack_dly[2]    = 2;
    ack_hold[3]   = 5;
    stage_data[5] = (DW'(64'hDEAD_BEEF) << 128) | DW'(16'h1234);
    local_cs_n  = 1'b1;
    local_rw    = 1'b0;
    local_addr  = '0;
    local_wdata = '0;
    Reset_N     = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_tab_cs_n", DW'(tab_cs_n), DW'(6'b111111));
    chk("rst_ack_n", DW'(local_ack_n), DW'(1'b1));
    chk("rst_err", DW'(local_err), DW'(1'b0));
    chk("rst_rdata", local_rdata, '0);
    chk("rst_tab_rw", DW'(tab_rw), DW'(1'b0));
    chk("rst_tab_addr", DW'(tab_addr), '0);
    chk("rst_tab_wdata", tab_wdata, '0);
    Reset_N = 1'b0;
    @(posedge Clk); #1;

    // Write to stage 2: strobe on edge 2, stage acks 3 strobe cycles later, host sees ack at edge 6.
    host_txn(1'b0, 3'd2, 14'h0ABC, {24{8'h5A}}, 50);
    chk_int("wr2_lat", lat, 6);
    chk("wr2_err", DW'(er), DW'(1'b0));
    chk("wr2_rdata", rd, '0);
    chk("wr2_cs_seen", DW'(cs_and), DW'(6'b111011));
    chk("wr2_tab_addr", DW'(t_addr), DW'(14'h0ABC));
    chk("wr2_tab_wdata", t_wd, {24{8'h5A}});
    chk("wr2_tab_rw", DW'(t_rw), DW'(1'b0));
    host_release(20);
    chk_int("wr2_release", rel, 2);

    // Read from stage 5 acking in the first WAIT cycle: 4-cycle round trip.
    host_txn(1'b1, 3'd5, 14'h0011, '0, 50);
    chk_int("rd5_lat", lat, 4);
    chk("rd5_rdata", rd, (DW'(64'hDEAD_BEEF) << 128) | DW'(16'h1234));
    chk("rd5_err", DW'(er), DW'(1'b0));
    chk("rd5_tab_rw", DW'(t_rw), DW'(1'b1));
    host_release(20);
    chk_int("rd5_release", rel, 2);

    // Invalid stage 7: no strobe, error ack on the 2nd edge.
    host_txn(1'b1, 3'd7, 14'h0001, '0, 50);
    chk_int("bad7_lat", lat, 2);
    chk("bad7_err", DW'(er), DW'(1'b1));
    chk("bad7_rdata", rd, '0);
    chk("bad7_cs_seen", DW'(cs_and), DW'(6'b111111));
    host_release(20);
    chk_int("bad7_release", rel, 1);

`ifdef AHEAP_LBUS_TIMEOUT_EN
    // Silent stage 0: strobe at edge 2, 17 WAIT cycles, error ack at edge 19.
    host_txn(1'b1, 3'd0, 14'h0002, '0, 40);
    chk_int("to0_lat", lat, TO + 3);
    chk("to0_err", DW'(er), DW'(1'b1));
    chk("to0_rdata", rd, {DW{1'b1}});
    host_release(20);
    chk_int("to0_release", rel, 1);
    host_txn(1'b1, 3'd0, 14'h0003, '0, 6);
    chk_int("wait0_no_ack", lat, -1);
`else
    host_txn(1'b1, 3'd0, 14'h0002, '0, 1000);
    chk_int("silent0_no_ack", lat, -1);
`endif

    // Controller is parked in WAIT on stage 0; reset must clear outputs without a clock edge.
    chk("wait0_cs", DW'(tab_cs_n), DW'(6'b111110));
    #2 Reset_N = 1'b1;
    #1;
    chk("arst_tab_cs_n", DW'(tab_cs_n), DW'(6'b111111));
    chk("arst_ack_n", DW'(local_ack_n), DW'(1'b1));
    chk("arst_tab_addr", DW'(tab_addr), '0);
    #1;
    Reset_N    = 1'b0;
    local_cs_n = 1'b1;
    @(posedge Clk); #1;

    host_txn(1'b1, 3'd1, 14'h0100, '0, 50);
    chk_int("rd1_lat", lat, 4);
    chk("rd1_rdata", rd, stage_data[1]);
    chk("rd1_err", DW'(er), DW'(1'b0));
    chk("rd1_tab_addr", DW'(t_addr), DW'(14'h0100));
    host_release(20);
    chk_int("rd1_release", rel, 2);

    // Stage 3 holds its ack 6 cycles past strobe release: ACK is held until it lets go.
    host_txn(1'b0, 3'd3, 14'h3FFF, {DW{1'b1}}, 50);
    chk_int("wr3_lat", lat, 4);
    chk("wr3_err", DW'(er), DW'(1'b0));
    host_release(30);
    chk_int("wr3_release_held", rel, 7);

    host_txn(1'b1, 3'd3, 14'h0005, '0, 50);
    chk_int("rd3_lat", lat, 4);
    chk("rd3_cs_seen", DW'(cs_and), DW'(6'b110111));
    chk("rd3_rdata", rd, stage_data[3]);
    host_release(30);
    chk_int("rd3_release", rel, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
